// File: rtl/risc_datapath.sv
// RISC datapath: 8x16 register file, A/B/C operand registers,
// shifter, ALU and {N,V,Z} status register.
module risc_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        loada,
  input  logic        loadb,
  input  logic        loadc,
  input  logic        loads,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  vsel,
  input  logic [2:0]  nsel,
  input  logic        write,
  output logic [15:0] datapath_out,
  output logic [2:0]  status
);

  logic [15:0] regs_q [8];
  logic [15:0] a_q, b_q, c_q;
  logic [2:0]  s_q;

  logic [1:0]  op;
  logic [1:0]  sh;
  logic [2:0]  rn, rd, rm;
  logic [7:0]  imm8;
  logic [4:0]  imm5;
  logic        unused_opc;

  assign op   = instr[12:11];
  assign rn   = instr[10:8];
  assign rd   = instr[7:5];
  assign sh   = instr[4:3];
  assign rm   = instr[2:0];
  assign imm8 = instr[7:0];
  assign imm5 = instr[4:0];
  assign unused_opc = ^instr[15:13];

  logic [2:0]  num;
  logic [15:0] rdata;
  logic [15:0] wb_d;

  // nsel is prioritised, so overlapping bits are legal
  always_comb begin
    if (nsel[2])      num = rn;
    else if (nsel[1]) num = rd;
    else              num = rm;
  end

  assign rdata = regs_q[num];

  always_comb begin
    unique case (vsel)
      2'b00:   wb_d = c_q;
      2'b01:   wb_d = 16'h0000;
      2'b10:   wb_d = {{8{imm8[7]}}, imm8};
      default: wb_d = {8'h00, imm8};
    endcase
  end

  logic [15:0] shout;
  logic [15:0] ain, bin;
  logic [15:0] alu_d;
  logic        v_d;
  logic [2:0]  s_d;

  always_comb begin
    unique case (sh)
      2'b00:   shout = b_q;
      2'b01:   shout = {b_q[14:0], 1'b0};
      2'b10:   shout = {1'b0, b_q[15:1]};
      default: shout = {b_q[15], b_q[15:1]};
    endcase
  end

  assign ain = asel ? 16'h0000 : a_q;
  assign bin = bsel ? {{11{imm5[4]}}, imm5}
                    : shout;

  always_comb begin
    v_d = 1'b0;
    unique case (op)
      2'b00: begin
        alu_d = ain + bin;
        v_d   = (ain[15] ~^ bin[15])
              & (alu_d[15] ^ ain[15]);
      end
      2'b01: begin
        alu_d = ain - bin;
        v_d   = (ain[15] ^ bin[15])
              & (alu_d[15] ^ ain[15]);
      end
      2'b10:   alu_d = ain & bin;
      default: alu_d = ~bin;
    endcase
  end

  assign s_d = {alu_d[15], v_d, alu_d == 16'h0000};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        regs_q[i] <= 16'h0000;
    end else if (write) begin
      regs_q[num] <= wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      c_q <= 16'h0000;
      s_q <= 3'b000;
    end else begin
      if (loada) a_q <= rdata;
      if (loadb) b_q <= rdata;
      if (loadc) c_q <= alu_d;
      if (loads) s_q <= s_d;
    end
  end

  assign datapath_out = c_q;
  assign status       = s_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Randomised + directed bench for risc_datapath against an
// integer-arithmetic model of the datapath.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel, write;
  logic [1:0]  vsel;
  logic [2:0]  nsel;
  logic [15:0] datapath_out;
  logic [2:0]  status;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .reset(reset), .instr(instr),
    .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel),
    .nsel(nsel), .write(write),
    .datapath_out(datapath_out), .status(status)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int mR[8];
  int mA, mB, mC, mN, mV, mZ;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_step();
    int rnf, rdf, rmf, num, rd, wb, sh, b2;
    int ain, bin, res, s, opv, i8, i5;
    int nN, nV, nZ;
    rnf = int'(instr[10:8]);
    rdf = int'(instr[7:5]);
    rmf = int'(instr[2:0]);
    sh  = int'(instr[4:3]);
    opv = int'(instr[12:11]);
    i8  = int'(instr[7:0]);
    i5  = int'(instr[4:0]);
    if (nsel[2])      num = rnf;
    else if (nsel[1]) num = rdf;
    else              num = rmf;
    rd = mR[num];
    case (vsel)
      2'd0: wb = mC;
      2'd1: wb = 0;
      2'd2: wb = (i8 >= 128) ? i8 + 'hFF00 : i8;
      default: wb = i8;
    endcase
    case (sh)
      0: b2 = mB;
      1: b2 = (mB * 2) % 65536;
      2: b2 = mB / 2;
      default: b2 = mB / 2 + (mB & 'h8000);
    endcase
    ain = asel ? 0 : mA;
    bin = bsel ? ((i5 >= 16) ? i5 + 'hFFE0 : i5) : b2;
    nV = 0;
    case (opv)
      0: begin
        res = (ain + bin) % 65536;
        s = sgn(ain) + sgn(bin);
        nV = (s > 32767 || s < -32768) ? 1 : 0;
      end
      1: begin
        res = (ain - bin + 65536) % 65536;
        s = sgn(ain) - sgn(bin);
        nV = (s > 32767 || s < -32768) ? 1 : 0;
      end
      2: res = ain & bin;
      default: res = 65535 - bin;
    endcase
    nN = (res >= 32768) ? 1 : 0;
    nZ = (res == 0) ? 1 : 0;
    if (reset) begin
      for (int i = 0; i < 8; i++) mR[i] = 0;
      mA = 0; mB = 0; mC = 0;
      mN = 0; mV = 0; mZ = 0;
    end else begin
      if (write) mR[num] = wb;
      if (loada) mA = rd;
      if (loadb) mB = rd;
      if (loadc) mC = res;
      if (loads) begin
        mN = nN; mV = nV; mZ = nZ;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("dout", int'(datapath_out), mC);
    chk("status", int'(status), mN * 4 + mV * 2 + mZ);
  endtask

  task automatic clr();
    reset = 0; loada = 0; loadb = 0;
    loadc = 0; loads = 0; asel = 0;
    bsel = 0; write = 0; vsel = 0; nsel = 0;
  endtask

  function automatic logic [15:0] mk(
      input logic [1:0] op, input logic [2:0] rn,
      input logic [2:0] rd, input logic [1:0] sh,
      input logic [2:0] rm);
    return {3'b101, op, rn, rd, sh, rm};
  endfunction

  task automatic setreg(input logic [2:0] r,
                        input logic [15:0] v);
    clr();
    instr = {3'b110, 2'b10, r, v[15:8]};
    nsel = 3'b100; vsel = 2'b11; write = 1;
    cycle();
    repeat (8) begin
      clr();
      instr = mk(2'b00, r, 3'd0, 2'b01, 3'd0);
      nsel = 3'b100; loadb = 1;
      cycle();
      clr(); asel = 1; loadc = 1;
      cycle();
      clr(); nsel = 3'b100; write = 1;
      cycle();
    end
    clr();
    instr = {3'b110, 2'b10, 3'd7, v[7:0]};
    nsel = 3'b100; vsel = 2'b11; write = 1;
    cycle();
    clr();
    instr = mk(2'b00, r, 3'd0, 2'b00, 3'd7);
    nsel = 3'b100; loada = 1;
    cycle();
    clr(); nsel = 3'b001; loadb = 1;
    cycle();
    clr(); loadc = 1;
    cycle();
    clr(); nsel = 3'b100; write = 1;
    cycle();
  endtask

  task automatic readreg(input logic [2:0] r);
    clr();
    instr = mk(2'b00, r, 3'd0, 2'b00, 3'd0);
    nsel = 3'b100; loada = 1;
    cycle();
    clr(); bsel = 1; loadc = 1;
    cycle();
  endtask

  initial begin
    clr();
    instr = 16'h0000;
    reset = 1;
    cycle();
    chk("reset_dout", int'(datapath_out), 0);
    chk("reset_status", int'(status), 0);

    clr(); instr = 16'hD1FF;
    nsel = 3'b100; vsel = 2'b10; write = 1;
    cycle();
    clr(); instr = mk(2'b00, 3'd1, 3'd0, 2'b00, 3'd0);
    nsel = 3'b100; loada = 1; cycle();
    clr(); nsel = 3'b100; loadb = 1; cycle();
    clr(); asel = 1; loadc = 1; cycle();
    chk("mov_imm", int'(datapath_out), 'hFFFF);

    setreg(3'd0, 16'd7);
    setreg(3'd1, 16'd2);
    clr(); instr = mk(2'b00, 3'd0, 3'd0, 2'b01, 3'd1);
    nsel = 3'b100; loada = 1; cycle();
    clr(); nsel = 3'b001; loadb = 1; cycle();
    clr(); loadc = 1; loads = 1; cycle();
    chk("add_shift", int'(datapath_out), 11);
    chk("add_status", int'(status), 0);

    setreg(3'd2, 16'h8000);
    setreg(3'd3, 16'h0001);
    clr(); instr = mk(2'b01, 3'd2, 3'd0, 2'b00, 3'd3);
    nsel = 3'b100; loada = 1; cycle();
    clr(); nsel = 3'b001; loadb = 1; cycle();
    clr(); loads = 1; cycle();
    chk("cmp_ovf", int'(status), 3'b010);

    setreg(3'd4, 16'h8004);
    clr(); instr = mk(2'b00, 3'd0, 3'd0, 2'b11, 3'd4);
    nsel = 3'b001; loadb = 1; cycle();
    clr(); asel = 1; loadc = 1; loads = 1; cycle();
    chk("asr", int'(datapath_out), 'hC002);
    chk("asr_status", int'(status), 3'b100);
    clr(); instr = mk(2'b11, 3'd0, 3'd0, 2'b00, 3'd4);
    loadc = 1; loads = 1; cycle();
    chk("mvn", int'(datapath_out), 'h7FFB);
    chk("mvn_status", int'(status), 3'b000);

    setreg(3'd2, 16'd5);
    clr(); instr = {3'b110, 2'b10, 3'd2, 8'd9};
    nsel = 3'b100; vsel = 2'b11;
    write = 1; loada = 1; cycle();
    clr(); instr = mk(2'b00, 3'd2, 3'd0, 2'b00, 3'd0);
    bsel = 1; loadc = 1; cycle();
    chk("rbw_a_old", int'(datapath_out), 5);
    readreg(3'd2);
    chk("rbw_r2_new", int'(datapath_out), 9);

    setreg(3'd3, 16'h1234);
    readreg(3'd3);
    chk("r3_set", int'(datapath_out), 'h1234);
    clr(); instr = {3'b110, 2'b10, 3'd3, 8'h55};
    nsel = 3'b100; vsel = 2'b11; write = 1;
    loada = 1; loadb = 1; loadc = 1; loads = 1;
    reset = 1;
    cycle();
    chk("rst_mid_dout", int'(datapath_out), 0);
    chk("rst_mid_status", int'(status), 0);
    for (int r = 0; r < 8; r++) begin
      readreg(r[2:0]);
      chk("rst_reg", int'(datapath_out), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      instr = 16'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      loada = 1'($urandom); loadb = 1'($urandom);
      loadc = 1'($urandom); loads = 1'($urandom);
      asel  = 1'($urandom); bsel  = 1'($urandom);
      write = 1'($urandom);
      vsel  = 2'($urandom); nsel  = 3'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
RISC_DATAPATH -- requirements
Module: risc_datapath

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port instr, input, 16 bits: held instruction; fields are opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
REQ-004 The block SHALL have the ports loada, loadb, loadc, loads, input, 1 bit each: load enables for registers A, B, C and status.
REQ-005 The block SHALL have the ports asel and bsel, input, 1 bit each: ALU operand selects.
REQ-006 The block SHALL have the port vsel, input, 2 bits: write-back source select.
REQ-007 The block SHALL have the port nsel, input, 3 bits: register select, one-hot; 100 = Rn, 010 = Rd, 001 = Rm.
REQ-008 The block SHALL have the port write, input, 1 bit: register-file write enable.
REQ-009 The block SHALL have the port datapath_out, output, 16 bits: contents of register C.
REQ-010 The block SHALL have the port status, output, 3 bits: {N, V, Z} flag register.

Function
REQ-011 The register file SHALL hold R0-R7, 16 bits each.
REQ-012 The register number SHALL be decoded from nsel by priority: nsel[2] selects Rn, else nsel[1] selects Rd, else Rm; nsel = 000 selects Rm.
REQ-013 The same decoded number SHALL be used for the combinational read and for the write.
REQ-014 The write-back value SHALL be chosen by vsel: 00 = C, 01 = 16'h0000, 10 = sign-extended imm8, 11 = {8'h00, imm8}.
REQ-015 When write = 1, the selected register SHALL update at the clock edge; other registers SHALL hold.
REQ-016 Read-before-write: if write and loada/loadb target the same register in one cycle, A/B SHALL capture the old value.
REQ-017 A SHALL load the read data when loada = 1, and B SHALL load the read data when loadb = 1; otherwise both hold.
REQ-018 The shifter SHALL act on B per sh: 00 = pass, 01 = shift left 1 (LSB 0), 10 = logical shift right 1 (MSB 0), 11 = arithmetic shift right 1 (MSB replicated).
REQ-019 ALU operand Ain SHALL be 16'h0000 when asel = 1, else A.
REQ-020 ALU operand Bin SHALL be sign-extended imm5 when bsel = 1, else the shifter output.
REQ-021 The ALU SHALL compute per op: 00 = Ain + Bin, 01 = Ain - Bin, 10 = Ain & Bin, 11 = ~Bin; results wrap modulo 2^16.
REQ-022 C SHALL load the ALU result when loadc = 1.
REQ-023 The status register SHALL load when loads = 1: Z = (result == 0), N = result[15], V = signed overflow for op 00/01, V = 0 for op 10/11.
REQ-024 The ALU and shifter SHALL be combinational from A, B and instr, so each load completes in one cycle.
REQ-025 Any combination of load enables and write SHALL be legal in the same cycle, each acting independently.
REQ-026 datapath_out SHALL be C directly, and status SHALL be the flag register directly, with no added latency.

Reset
REQ-027 On reset, R0-R7, A, B, C and status SHALL clear to 0, so datapath_out = 0 and status = 000 on the next cycle.
REQ-028 Reset SHALL take priority over write and all load enables in the same cycle.
REQ-029 Reset asserted mid-instruction SHALL discard any pending operation; no partial write SHALL survive.

Verification
REQ-030 MOV immediate: instr = 16'hD1FF (Rn = R1, imm8 = FF), nsel = 100, vsel = 10, write = 1 -> R1 = 16'hFFFF; nsel = 100, loada = 1 then loadb = 1 with asel = 1, loadc = 1 -> datapath_out = 16'hFFFF.
REQ-031 ADD with shift: R0 = 7, R1 = 2, instr fields Rn = R0, Rm = R1, sh = 01, op = 00 -> loada (Rn), then loadb (Rm), then loadc/loads -> datapath_out = 11, status = 000.
REQ-032 CMP overflow: A = 16'h8000, B = 1, op = 01, loads = 1 -> status N = 0, V = 1, Z = 0; C unchanged when loadc = 0.
REQ-033 ASR and MVN: B = 16'h8004, sh = 11, asel = 1, op = 00 -> C = 16'hC002; then op = 11, sh = 00 -> C = 16'h7FFB, status N = 0.
REQ-034 Read-before-write: R2 = 5; write 9 to R2 with loada = 1 on R2 in the same cycle -> A = 5, R2 = 9.
REQ-035 Reset mid-operation: with R3 = 16'h1234, assert reset together with write = 1 -> all registers = 0 and datapath_out = 0 on the next cycle.
